// File: rtl/hazard_detect.sv
// hazard_detect: ID-stage hazard unit for a 5-stage pipeline with branches
// resolved in ID.
//
// It tracks the destinations of the instructions now in EX and MEM in a
// two-slot shadow pipeline. From those slots and the ID instruction it
// decides whether to stall ID/IF for a cycle, or whether to flush IF/ID when
// a jump or a taken branch is in ID.
//
// Ports
//   clk_i        pipeline clock, rising edge
//   rst_i        synchronous active-high reset
//   valid_i      ID holds a real instruction
//   Op_i         ID opcode
//   RS_i/RT_i/RD_i  ID register fields
//   Equal_i      ID comparator result (rs == rt)
//   Hazard_o     bubble request to the control unit
//   PCWrite_o    PC enable
//   IFIDWrite_o  IF/ID enable
//   Flush_o      discard the fetched instruction (clear IF/ID)
//   stall_cnt_o  saturating count of stall cycles since reset
module hazard_detect #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [5:0]       Op_i,
  input  logic [4:0]       RS_i,
  input  logic [4:0]       RT_i,
  input  logic [4:0]       RD_i,
  input  logic             Equal_i,
  output logic             Hazard_o,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             Flush_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       valid;
    logic [4:0] dest;
    logic       isLoad;
  } slot_t;

  slot_t exSlot, memSlot, exNext;

  logic       useRs, useRt, hasDest, isLoad, isBeq, isJump;
  logic [4:0] destReg;
  logic       exMatch, memMatch, stall;
  logic [CNT_W-1:0] stallCnt;

  // ID decode; unlisted opcodes read nothing and write nothing
  always_comb begin
    useRs   = 1'b0;
    useRt   = 1'b0;
    hasDest = 1'b0;
    destReg = 5'd0;
    isLoad  = 1'b0;
    isBeq   = 1'b0;
    isJump  = 1'b0;
    case (Op_i)
      OP_RTYPE: begin useRs = 1'b1; useRt = 1'b1; hasDest = 1'b1; destReg = RD_i; end
      OP_ADDI:  begin useRs = 1'b1; hasDest = 1'b1; destReg = RT_i; end
      OP_LW:    begin useRs = 1'b1; hasDest = 1'b1; destReg = RT_i; isLoad = 1'b1; end
      OP_SW:    begin useRs = 1'b1; useRt = 1'b1; end
      OP_BEQ:   begin useRs = 1'b1; useRt = 1'b1; isBeq = 1'b1; end
      OP_J:     isJump = 1'b1;
      default:  ;
    endcase
  end

  // $0 is never a producer, so a zero source never matches a slot. beq reads
  // both rs and rt, so "dest equals rs or rt" is the same as a source match.
  always_comb begin
    exMatch  = (useRs && RS_i != 5'd0 && RS_i == exSlot.dest) ||
               (useRt && RT_i != 5'd0 && RT_i == exSlot.dest);
    memMatch = (useRs && RS_i != 5'd0 && RS_i == memSlot.dest) ||
               (useRt && RT_i != 5'd0 && RT_i == memSlot.dest);
  end

  // Loads forward from MEM only; branches compare in ID so they also wait on
  // any EX producer and on a load still in MEM.
  assign stall = valid_i && (
                   (exSlot.valid && exSlot.isLoad && exMatch) ||
                   (isBeq && exSlot.valid && exMatch) ||
                   (isBeq && memSlot.valid && memSlot.isLoad && memMatch));

  // Reset masks the outputs so stale slot contents cannot leak out.
  assign Hazard_o    = stall && !rst_i;
  assign PCWrite_o   = !stall || rst_i;
  assign IFIDWrite_o = !stall || rst_i;
  assign Flush_o     = valid_i && !stall && !rst_i && (isJump || (isBeq && Equal_i));
  assign stall_cnt_o = stallCnt;

  // A stalled or empty ID slot becomes a bubble in EX; writes to $0 are
  // dropped here so they never look like producers.
  always_comb begin
    exNext = '0;
    if (valid_i && !stall && hasDest && destReg != 5'd0) begin
      exNext.valid  = 1'b1;
      exNext.dest   = destReg;
      exNext.isLoad = isLoad;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exSlot   <= '0;
      memSlot  <= '0;
      stallCnt <= '0;
    end else begin
      memSlot <= exSlot;
      exSlot  <= exNext;
      if (stall && stallCnt != {CNT_W{1'b1}})
        stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_detect.sv
module tb_hazard_detect;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, Equal_i;
  logic [5:0]  Op_i;
  logic [4:0]  RS_i, RT_i, RD_i;
  logic        Hazard_o, PCWrite_o, IFIDWrite_o, Flush_o;
  logic [15:0] stall_cnt_o;
  logic        sHazard, sPCWrite, sIFIDWrite, sFlush;
  logic [3:0]  sCnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk_i = ~clk_i;

  hazard_detect dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
    .RS_i(RS_i), .RT_i(RT_i), .RD_i(RD_i), .Equal_i(Equal_i),
    .Hazard_o(Hazard_o), .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
    .Flush_o(Flush_o), .stall_cnt_o(stall_cnt_o)
  );

  // 4-bit counter copy: saturation is reached after 15 stalls
  hazard_detect #(.CNT_W(4)) satDut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
    .RS_i(RS_i), .RT_i(RT_i), .RD_i(RD_i), .Equal_i(Equal_i),
    .Hazard_o(sHazard), .PCWrite_o(sPCWrite), .IFIDWrite_o(sIFIDWrite),
    .Flush_o(sFlush), .stall_cnt_o(sCnt)
  );

  // Present one ID instruction for a cycle; outputs settle 1ns later.
  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic eq);
    @(negedge clk_i);
    valid_i = v; Op_i = op; RS_i = rs; RT_i = rt; RD_i = rd; Equal_i = eq;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i = 1'b1; valid_i = 1'b1; Op_i = OP_J; RS_i = 0; RT_i = 0; RD_i = 0; Equal_i = 1'b1;
    #1;
    compared++;
    if (Flush_o !== 1'b0 || Hazard_o !== 1'b0) begin
      mismatched++; $display("FAIL reset_outs flush=%b hazard=%b want 0 0", Flush_o, Hazard_o);
    end
    compared++;
    if (PCWrite_o !== 1'b1 || IFIDWrite_o !== 1'b1) begin
      mismatched++; $display("FAIL reset_writes pc=%b ifid=%b want 1 1", PCWrite_o, IFIDWrite_o);
    end
    @(negedge clk_i);
    compared++;
    if (stall_cnt_o !== 16'd0 || sCnt !== 4'd0) begin
      mismatched++; $display("FAIL reset_cnt got %0d/%0d want 0", stall_cnt_o, sCnt);
    end
    rst_i = 1'b0; valid_i = 1'b0;
  endtask

  task automatic test_load_use();
    doReset();
    drive(1, OP_LW, 5'd1, 5'd2, 5'd0, 0);
    compared++;
    if (Hazard_o !== 1'b0) begin mismatched++; $display("FAIL lu_lw hazard=%b want 0", Hazard_o); end
    drive(1, OP_R, 5'd2, 5'd4, 5'd3, 0);
    compared++;
    if (Hazard_o !== 1'b1 || PCWrite_o !== 1'b0 || IFIDWrite_o !== 1'b0) begin
      mismatched++; $display("FAIL lu_stall hz/pc/ifid=%b%b%b want 100", Hazard_o, PCWrite_o, IFIDWrite_o);
    end
    drive(1, OP_R, 5'd2, 5'd4, 5'd3, 0);
    compared++;
    if (Hazard_o !== 1'b0 || PCWrite_o !== 1'b1) begin
      mismatched++; $display("FAIL lu_release hz=%b pc=%b want 0 1", Hazard_o, PCWrite_o);
    end
    compared++;
    if (stall_cnt_o !== 16'd1) begin mismatched++; $display("FAIL lu_cnt got %0d want 1", stall_cnt_o); end
  endtask

  task automatic test_load_branch();
    doReset();
    drive(1, OP_LW, 5'd1, 5'd2, 5'd0, 1);
    drive(1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1);
    compared++;
    if (Hazard_o !== 1'b1 || Flush_o !== 1'b0) begin
      mismatched++; $display("FAIL lb_stall1 hz=%b fl=%b want 1 0", Hazard_o, Flush_o);
    end
    drive(1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1);
    compared++;
    if (Hazard_o !== 1'b1 || Flush_o !== 1'b0) begin
      mismatched++; $display("FAIL lb_stall2 hz=%b fl=%b want 1 0", Hazard_o, Flush_o);
    end
    drive(1, OP_BEQ, 5'd2, 5'd5, 5'd0, 1);
    compared++;
    if (Hazard_o !== 1'b0 || Flush_o !== 1'b1) begin
      mismatched++; $display("FAIL lb_release hz=%b fl=%b want 0 1", Hazard_o, Flush_o);
    end
    compared++;
    if (stall_cnt_o !== 16'd2) begin mismatched++; $display("FAIL lb_cnt got %0d want 2", stall_cnt_o); end
  endtask

  task automatic test_alu_branch();
    doReset();
    drive(1, OP_R, 5'd1, 5'd1, 5'd3, 0);
    drive(1, OP_BEQ, 5'd3, 5'd3, 5'd0, 1);
    compared++;
    if (Hazard_o !== 1'b1 || Flush_o !== 1'b0) begin
      mismatched++; $display("FAIL ab_stall hz=%b fl=%b want 1 0", Hazard_o, Flush_o);
    end
    drive(1, OP_BEQ, 5'd3, 5'd3, 5'd0, 1);
    compared++;
    if (Hazard_o !== 1'b0 || Flush_o !== 1'b1) begin
      mismatched++; $display("FAIL ab_flush hz=%b fl=%b want 0 1", Hazard_o, Flush_o);
    end
    drive(0, OP_R, 5'd0, 5'd0, 5'd0, 0);
    compared++;
    if (Flush_o !== 1'b0 || stall_cnt_o !== 16'd1) begin
      mismatched++; $display("FAIL ab_after fl=%b cnt=%0d want 0 1", Flush_o, stall_cnt_o);
    end
  endtask

  task automatic test_jump_zero();
    doReset();
    drive(1, OP_J, 5'd0, 5'd0, 5'd0, 0);
    compared++;
    if (Flush_o !== 1'b1 || Hazard_o !== 1'b0) begin
      mismatched++; $display("FAIL j_flush fl=%b hz=%b want 1 0", Flush_o, Hazard_o);
    end
    drive(1, OP_LW, 5'd1, 5'd0, 5'd0, 0);
    drive(1, OP_R, 5'd0, 5'd0, 5'd3, 1);
    compared++;
    if (Hazard_o !== 1'b0 || Flush_o !== 1'b0) begin
      mismatched++; $display("FAIL zero_reg hz=%b fl=%b want 0 0", Hazard_o, Flush_o);
    end
    // invalid ID never stalls or flushes
    drive(1, OP_LW, 5'd1, 5'd2, 5'd0, 0);
    drive(0, OP_BEQ, 5'd2, 5'd2, 5'd0, 1);
    compared++;
    if (Hazard_o !== 1'b0 || Flush_o !== 1'b0) begin
      mismatched++; $display("FAIL invalid_id hz=%b fl=%b want 0 0", Hazard_o, Flush_o);
    end
  endtask

  task automatic test_decode();
    logic [5:0] ops [4] = '{OP_SW, OP_ADDI, OP_ADDI, OP_BAD};
    logic [4:0] rss [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    logic       exp [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      doReset();
      drive(1, OP_LW, 5'd1, 5'd2, 5'd0, 0);
      drive(1, ops[i], rss[i], 5'd2, 5'd2, 0);
      compared++;
      if (Hazard_o !== exp[i]) begin
        mismatched++; $display("FAIL decode[%0d] op=%b hz=%b want %b", i, ops[i], Hazard_o, exp[i]);
      end
    end
  endtask

  task automatic test_distance();
    doReset();
    drive(1, OP_LW, 5'd1, 5'd2, 5'd0, 0);
    drive(1, OP_R, 5'd1, 5'd1, 5'd6, 0);
    drive(1, OP_BEQ, 5'd2, 5'd7, 5'd0, 0);
    compared++;
    if (Hazard_o !== 1'b1) begin mismatched++; $display("FAIL lw2_beq hz=%b want 1", Hazard_o); end
    drive(1, OP_BEQ, 5'd2, 5'd7, 5'd0, 0);
    compared++;
    if (Hazard_o !== 1'b0 || stall_cnt_o !== 16'd1) begin
      mismatched++; $display("FAIL lw2_beq_rel hz=%b cnt=%0d want 0 1", Hazard_o, stall_cnt_o);
    end
    drive(1, OP_R, 5'd1, 5'd1, 5'd8, 0);
    drive(1, OP_R, 5'd1, 5'd1, 5'd9, 0);
    drive(1, OP_BEQ, 5'd8, 5'd0, 5'd0, 0);
    compared++;
    if (Hazard_o !== 1'b0) begin mismatched++; $display("FAIL alu2_beq hz=%b want 0", Hazard_o); end
  endtask

  task automatic test_reset_mid_stall();
    doReset();
    drive(1, OP_LW, 5'd1, 5'd2, 5'd0, 0);
    drive(1, OP_BEQ, 5'd2, 5'd5, 5'd0, 0);
    compared++;
    if (Hazard_o !== 1'b1) begin mismatched++; $display("FAIL ms_pre hz=%b want 1", Hazard_o); end
    rst_i = 1'b1;
    #1;
    compared++;
    if (Hazard_o !== 1'b0 || PCWrite_o !== 1'b1 || IFIDWrite_o !== 1'b1) begin
      mismatched++; $display("FAIL ms_inrst hz/pc/ifid=%b%b%b want 011", Hazard_o, PCWrite_o, IFIDWrite_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    compared++;
    if (Hazard_o !== 1'b0 || stall_cnt_o !== 16'd0) begin
      mismatched++; $display("FAIL ms_after hz=%b cnt=%0d want 0 0", Hazard_o, stall_cnt_o);
    end
  endtask

  task automatic test_saturation();
    int expS;
    doReset();
    for (int i = 1; i <= 20; i++) begin
      drive(1, OP_LW, 5'd1, 5'd2, 5'd0, 0);
      drive(1, OP_R, 5'd2, 5'd4, 5'd3, 0);
      drive(1, OP_R, 5'd2, 5'd4, 5'd3, 0);
      expS = (i > 15) ? 15 : i;
      compared++;
      if (stall_cnt_o !== 16'(i) || sCnt !== 4'(expS)) begin
        mismatched++;
        $display("FAIL sat[%0d] cnt=%0d/%0d want %0d/%0d", i, stall_cnt_o, sCnt, i, expS);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; Op_i = '0; RS_i = '0; RT_i = '0; RD_i = '0; Equal_i = 1'b0;
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_jump_zero();
    test_decode();
    test_distance();
    test_reset_mid_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
